// File: rtl/mmio_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// | mmio_uart_tx_pkg                                                        |
// | Register offsets, STATUS bit positions and shift FSM encodings.         |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package mmio_uart_tx_pkg;

    localparam logic [31:0] TXDATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS   = 32'h0000_0004;

    localparam int          ST_FULL_BIT  = 0;
    localparam int          ST_EMPTY_BIT = 1;
    localparam int          ST_BUSY_BIT  = 2;
    localparam int          ST_OVF_BIT   = 3;
    localparam int          ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// | mmio_uart_tx_sync_fifo                                                  |
// | Show-ahead synchronous FIFO; a push into a full FIFO is accepted only   |
// | when a pop happens on the same edge.                                    |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// | mmio_uart_tx                                                            |
// | Memory-mapped 8N1 UART transmitter with TXDATA/STATUS registers.        |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr_sig,
    input  logic [31:0] mem_wr_data,
    output logic [31:0] mem_rd_data,
    output logic        sel,
    output logic        tx,
    output logic        irq_empty
);

    localparam int                BAUD_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              irq_q, irq_d;
    logic              ovf_q, ovf_d;

    logic              w_hit_tx, w_hit_status, w_wr_tx, w_wr_status;
    logic              w_pop, w_baud_end;
    logic [7:0]        w_fifo_dout;
    logic              w_fifo_full, w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [31:0]       w_status;
    logic              w_unused_wdata;

    assign w_hit_tx       = (mem_addr == BASE_ADDR + TXDATA_OFS);
    assign w_hit_status   = (mem_addr == BASE_ADDR + STATUS_OFS);
    assign w_wr_tx        = mem_wr_sig && w_hit_tx;
    assign w_wr_status    = mem_wr_sig && w_hit_status;
    assign sel            = w_hit_tx || w_hit_status;
    assign w_unused_wdata = ^mem_wr_data[31:8];

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_wr_tx),
        .data_i  (mem_wr_data[7:0]),
        .pop_i   (w_pop),
        .data_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    always_comb begin
        w_status                        = '0;
        w_status[ST_FULL_BIT]           = w_fifo_full;
        w_status[ST_EMPTY_BIT]          = w_fifo_empty;
        w_status[ST_BUSY_BIT]           = (state_q != S_IDLE);
        w_status[ST_OVF_BIT]            = ovf_q;
        w_status[ST_COUNT_LSB +: 8]     = 8'(w_fifo_count);
    end

    assign mem_rd_data = w_hit_status ? w_status : 32'h0;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        w_pop      = 1'b0;
        w_baud_end = (baud_q == BAUD_MAX);
        if (state_q != S_IDLE) baud_d = w_baud_end ? '0 : baud_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_fifo_dout;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_baud_end) begin
                    if (!w_fifo_empty) begin
                        w_pop   = 1'b1;
                        shift_d = w_fifo_dout;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[bit_q];
            default: tx_d = 1'b1;
        endcase

        irq_d = (state_q == S_IDLE) && w_fifo_empty && !w_wr_tx;

        ovf_d = ovf_q;
        if (w_wr_tx && w_fifo_full && !w_pop)           ovf_d = 1'b1;
        if (w_wr_status && mem_wr_data[ST_OVF_BIT])     ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx        = tx_q;
    assign irq_empty = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// | tb_mmio_uart_tx                                                         |
// | Directed and random bus traffic against a cycle-timed transaction model.|
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mmio_uart_tx;

    localparam int          CPB   = 16;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] STAT  = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_wr_sig = 1'b0;
    logic [31:0] mem_wr_data = '0;
    logic [31:0] mem_rd_data;
    logic        sel, tx, irq_empty;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: pending bytes, the frame currently on the wire, and the edge at
    // which the serialiser next becomes free (each frame occupies FRAME edges).
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [8:0] rx_q[$];
    int         cyc = 0;
    int         free_at = 0;
    int         cur_p = 0;
    bit         have_frame = 0;
    logic [7:0] cur_byte = '0;
    bit         m_ovf = 0;
    logic       m_irq = 1'b1;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_addr    (mem_addr),
        .mem_wr_sig  (mem_wr_sig),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .sel         (sel),
        .tx          (tx),
        .irq_empty   (irq_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        int j;
        k = cyc - 1 - cur_p;
        if (!have_frame || k < 0 || k >= FRAME) return 1'b1;
        j = k / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return cur_byte[j-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (mq.size() == DEPTH);
        s[1]    = (mq.size() == 0);
        s[2]    = (cyc < free_at);
        s[3]    = m_ovf;
        s[15:8] = 8'(mq.size());
        return s;
    endfunction

    task automatic model_edge(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bit pre_busy;
        bit pre_empty;
        bit push_req;
        pre_busy  = (cyc - 1) < free_at;
        pre_empty = (mq.size() == 0);
        push_req  = wr && (addr == BASE);
        m_irq     = !pre_busy && pre_empty && !push_req;
        if (cyc >= free_at && !pre_empty) begin
            cur_byte   = mq.pop_front();
            sent_q.push_back(cur_byte);
            cur_p      = cyc;
            have_frame = 1;
            free_at    = cyc + FRAME;
        end
        if (push_req) begin
            if (mq.size() < DEPTH) mq.push_back(data[7:0]);
            else                   m_ovf = 1;
        end
        if (wr && addr == STAT && data[3]) m_ovf = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        cyc        = 0;
        free_at    = 0;
        have_frame = 0;
        m_ovf      = 0;
        m_irq      = 1'b1;
    endtask

    task automatic step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        mem_wr_sig  = wr;
        mem_addr    = addr;
        mem_wr_data = data;
        @(posedge clk);
        cyc++;
        model_edge(wr, addr, data);
        #1;
        chk("tx", {31'h0, tx}, {31'h0, exp_tx()});
        chk("irq_empty", {31'h0, irq_empty}, {31'h0, m_irq});
        chk("sel", {31'h0, sel}, {31'h0, (addr == BASE || addr == STAT)});
        chk("rd_data", mem_rd_data, (addr == STAT) ? exp_status() : 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, STAT, 32'h0);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((mq.size() != 0 || cyc < free_at || irq_empty !== 1'b1) && n < bound) begin
            step(1'b0, STAT, 32'h0);
            n++;
        end
        chk("drain_in_time", {31'h0, (n < bound)}, 32'h1);
        idle(4);
    endtask

    // Line decoder: samples mid-bit, records {stop, data}.
    initial begin : decoder
        logic [8:0] w;
        forever begin
            @(negedge tx);
            if (reset_n) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    w[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                w[8] = tx;
                rx_q.push_back(w);
            end
        end
    end

    initial begin : main
        int t0;
        int n;
        logic [31:0] a;
        logic [31:0] d;
        int r;

        // Reset state
        mem_addr = STAT;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_irq", {31'h0, irq_empty}, 32'h1);
        chk("rst_status", mem_rd_data, 32'h0000_0002);
        reset_n = 1'b1;
        model_reset();

        // 1: idle line
        idle(100);
        chk("t1_status", mem_rd_data, 32'h0000_0002);

        // 2: single frame, upper bytes ignored
        rx_q.delete();
        step(1'b1, BASE, 32'hFFFF_FF55);
        chk("t2_lat0", {31'h0, tx}, 32'h1);
        idle(1);
        chk("t2_lat1", {31'h0, tx}, 32'h1);
        idle(1);
        chk("t2_lat2", {31'h0, tx}, 32'h0);
        drain(FRAME + 20);
        chk("t2_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t2_rx_byte", {23'h0, rx_q[0]}, 32'h155);

        // 3: back-to-back frames, irq after both
        rx_q.delete();
        t0 = cyc + 1;
        step(1'b1, BASE, 32'h48);
        step(1'b1, BASE, 32'h69);
        idle(FRAME);
        chk("t3_busy", mem_rd_data & 32'h4, 32'h4);
        n = 0;
        while (irq_empty !== 1'b1 && n < 2 * FRAME) begin
            idle(1);
            n++;
        end
        chk("t3_irq_rise", cyc - t0, 2 + 2 * FRAME);
        idle(2);
        chk("t3_rx_count", rx_q.size(), 2);
        if (rx_q.size() > 1) begin
            chk("t3_rx0", {23'h0, rx_q[0]}, 32'h148);
            chk("t3_rx1", {23'h0, rx_q[1]}, 32'h169);
        end

        // 4: overflow on the tenth consecutive store
        for (int i = 0; i < 10; i++) step(1'b1, BASE, $urandom);
        idle(1);
        chk("t4_status_ovf", mem_rd_data, 32'h0000_080D);
        step(1'b1, STAT, 32'h8);
        idle(1);
        chk("t4_status_clr", mem_rd_data, 32'h0000_0805);

        // 5: push on the pop edge while full
        n = 0;
        while (cyc + 1 != free_at && n < 2 * FRAME) begin
            idle(1);
            n++;
        end
        step(1'b1, BASE, 32'hA5);
        idle(1);
        chk("t5_status", mem_rd_data, 32'h0000_0805);

        // 6: reset in the middle of the data bits
        n = 0;
        while (!(have_frame && (cyc - 1 - cur_p) == 3 * CPB + 5) && n < 2 * FRAME) begin
            idle(1);
            n++;
        end
        chk("t6_reached_data", {31'h0, (n < 2 * FRAME)}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_tx_async", {31'h0, tx}, 32'h1);
        chk("t6_irq_async", {31'h0, irq_empty}, 32'h1);
        chk("t6_status_async", mem_rd_data, 32'h0000_0002);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        idle(200);
        chk("t6_status_after", mem_rd_data, 32'h0000_0002);

        // Random bus traffic
        rx_q.delete();
        sent_q.delete();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            d = $urandom;
            if (r <= 2)      step(1'b1, BASE, d);
            else if (r == 3) step(1'b1, STAT, d);
            else if (r == 4) begin
                a = (d[0]) ? (BASE + 32'(4 * $urandom_range(2, 5))) : $urandom;
                step(1'b0, a, d);
            end else         step(1'b0, STAT, 32'h0);
        end
        drain(DEPTH * FRAME + 2 * FRAME);
        chk("rand_rx_count", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            chk("rand_rx_byte", {23'h0, rx_q[i]}, {23'h0, 1'b1, sent_q[i]});

        // 7: program prints "55\n"
        rx_q.delete();
        step(1'b1, BASE, 32'h35);
        idle(3);
        step(1'b1, BASE, 32'h35);
        idle(5);
        step(1'b1, BASE, 32'h0A);
        drain(4 * FRAME);
        chk("t7_rx_count", rx_q.size(), 3);
        if (rx_q.size() > 2) begin
            chk("t7_rx0", {23'h0, rx_q[0]}, 32'h135);
            chk("t7_rx1", {23'h0, rx_q[1]}, 32'h135);
            chk("t7_rx2", {23'h0, rx_q[2]}, 32'h10A);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
